if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter NBITS, default 32: width of PC values and instruction words.
REQ-002 SHALL have parameter IMEM_DEPTH, default 256: instruction memory depth in words, power of two; AW = log2(IMEM_DEPTH).
REQ-003 SHALL have port i_clk  in  1: single clock; all state updates on posedge.
REQ-004 SHALL have port i_reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port i_step  in  1: pipeline advance enable from the debug unit.
REQ-006 SHALL have port i_stall  in  1: hazard stall; hold the IF/ID register.
REQ-007 SHALL have port i_flush  in  1: branch/jump taken; squash the fetched instruction.
REQ-008 SHALL have port i_pc  in  NBITS: current PC from the PC register.
REQ-009 SHALL have port i_pc_4  in  NBITS: PC+4 from the PC register.
REQ-010 SHALL have port i_load_valid  in  1: program-load byte strobe.
REQ-011 SHALL have port i_load_byte  in  8: program-load data byte.
REQ-012 SHALL have port i_load_clear  in  1: restart program load at word 0.
REQ-013 SHALL have port o_instr  out  NBITS: IF/ID instruction register.
REQ-014 SHALL have port o_pc_4  out  NBITS: IF/ID PC+4 register.
REQ-015 SHALL have port o_load_count  out  AW+1: number of words written since the last clear or reset.
REQ-016 SHALL have port o_load_full  out  1: high when o_load_count == IMEM_DEPTH.
REQ-017 SHALL have port o_halt  out  1: sticky HALT-fetched flag.

Function
REQ-018 SHALL read memory asynchronously at word index i_pc[AW+1:2] and ignore i_pc[1:0].
REQ-019 SHALL substitute 0 (NOP) for the fetched word when i_pc[NBITS-1:AW+2] != 0.
REQ-020 SHALL update the IF/ID register at posedge only when i_step=1; when i_step=0 it holds.
REQ-021 SHALL, with i_step=1 and i_flush=1, load o_instr=0 and o_pc_4=i_pc_4 in the same edge.
REQ-022 SHALL, with i_step=1, i_flush=0 and i_stall=1, hold o_instr and o_pc_4.
REQ-023 SHALL, with i_step=1, i_flush=0 and i_stall=0, load o_instr=fetched word and o_pc_4=i_pc_4.
REQ-024 SHALL give flush priority over stall when both are asserted.
REQ-025 SHALL assemble load bytes big-endian: the 1st accepted byte goes to [31:24] and the 4th to [7:0], using a 2-bit byte counter 0..3.
REQ-026 SHALL, on the edge accepting the 4th byte, write the assembled word to mem[o_load_count], increment o_load_count, and return the byte counter to 0.
REQ-027 SHALL ignore i_load_valid while o_load_full=1, leaving the byte counter unchanged.
REQ-028 SHALL, on i_load_clear, zero o_load_count and the byte counter, with priority over a same-cycle i_load_valid; memory contents are kept.
REQ-029 SHALL return the old memory word to a same-cycle read at an address being written.
REQ-030 SHALL operate loading independently of i_step, i_stall and i_flush.

Reset
REQ-031 SHALL, on i_reset at posedge, set o_instr=0, o_pc_4=0, o_load_count=0, byte counter=0 and o_halt=0.
REQ-032 SHALL leave memory contents unchanged on reset.
REQ-033 SHALL make reset override step, flush, stall and load in the same cycle, discarding any partially assembled word.

Configuration
REQ-034 SHALL, with IF_HALT_DETECT_EN defined, set o_halt=1 on the edge that loads 32'hFFFFFFFF into o_instr, and hold it until reset.
REQ-035 SHALL, with IF_HALT_DETECT_EN defined, leave o_halt unaffected by flush and stall.
REQ-036 SHALL, without IF_HALT_DETECT_EN, tie o_halt to 0 and pass 32'hFFFFFFFF through as an ordinary word.

Verification
REQ-037 SHALL cover load: bytes 0x20,0x08,0x00,0x05 -> mem[0]=0x20080005, o_load_count=1; then i_pc=0, step -> o_instr=0x20080005, o_pc_4=4.
REQ-038 SHALL cover overflow: load 4*IMEM_DEPTH bytes, then 4 more -> o_load_full=1, o_load_count=IMEM_DEPTH, mem[0] unchanged.
REQ-039 SHALL cover flush and stall: i_stall=1 with i_flush=1, step -> o_instr=0, o_pc_4=i_pc_4; i_stall=1 with i_flush=0 -> o_instr held.
REQ-040 SHALL cover step gating: i_step=0 for 5 cycles while i_pc changes -> o_instr and o_pc_4 constant.
REQ-041 SHALL cover out-of-range fetch: i_pc=0x00000400 with IMEM_DEPTH=256, step -> o_instr=0.
REQ-042 SHALL cover HALT and mid-load reset: fetch 0xFFFFFFFF -> o_halt=1 with macro defined, 0 without; reset after 2 load bytes -> byte counter 0 and o_halt=0.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: async-read instruction memory, byte-serial program loader,
// and the IF/ID instruction/PC+4 register. Optional sticky HALT detect under IF_HALT_DETECT_EN.
module if_id_stage #(
  parameter int unsigned NBITS      = 32,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_step,
  input  logic                               i_stall,
  input  logic                               i_flush,
  input  logic [NBITS-1:0]                   i_pc,
  input  logic [NBITS-1:0]                   i_pc_4,
  input  logic                               i_load_valid,
  input  logic [7:0]                         i_load_byte,
  input  logic                               i_load_clear,
  output logic [NBITS-1:0]                   o_instr,
  output logic [NBITS-1:0]                   o_pc_4,
  output logic [$clog2(IMEM_DEPTH):0]        o_load_count,
  output logic                               o_load_full,
  output logic                               o_halt
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [NBITS-1:0] mem_q [IMEM_DEPTH];

  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] pc_4_q, pc_4_d;
  logic [CW-1:0]    load_count_q, load_count_d;
  logic             load_full_q, load_full_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [23:0]      byte_buf_q, byte_buf_d;

  logic [AW-1:0]    rd_idx_c;
  logic             pc_in_range_c;
  logic [NBITS-1:0] fetch_word_c;
  logic             load_accept_c;
  logic             word_done_c;
  logic [31:0]      load_word_c;
  logic             unused_c;

  // Word-aligned fetch; addresses beyond the memory read as NOP.
  assign rd_idx_c      = i_pc[AW+1:2];
  assign pc_in_range_c = ((i_pc >> (AW + 2)) == '0);
  assign fetch_word_c  = pc_in_range_c ? mem_q[rd_idx_c] : '0;
  assign unused_c      = ^i_pc[1:0];

  assign load_accept_c = i_load_valid && !i_load_clear && !load_full_q;
  assign word_done_c   = load_accept_c && (byte_cnt_q == 2'd3);
  assign load_word_c   = {byte_buf_q, i_load_byte};

  // Loader next state: clear wins over a same-cycle byte.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    byte_buf_d   = byte_buf_q;
    load_count_d = load_count_q;
    if (i_load_clear) begin
      byte_cnt_d   = 2'd0;
      load_count_d = '0;
    end else if (load_accept_c) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      byte_buf_d = {byte_buf_q[15:0], i_load_byte};
      if (word_done_c) begin
        load_count_d = load_count_q + CW'(1);
      end
    end
    load_full_d = (load_count_d == CW'(IMEM_DEPTH));
  end

  // IF/ID register next state: flush beats stall, nothing moves without step.
  always_comb begin
    instr_d = instr_q;
    pc_4_d  = pc_4_q;
    if (i_step) begin
      if (i_flush) begin
        instr_d = '0;
        pc_4_d  = i_pc_4;
      end else if (!i_stall) begin
        instr_d = fetch_word_c;
        pc_4_d  = i_pc_4;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instr_q      <= '0;
      pc_4_q       <= '0;
      load_count_q <= '0;
      load_full_q  <= 1'b0;
      byte_cnt_q   <= 2'd0;
      byte_buf_q   <= '0;
    end else begin
      instr_q      <= instr_d;
      pc_4_q       <= pc_4_d;
      load_count_q <= load_count_d;
      load_full_q  <= load_full_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_buf_q   <= byte_buf_d;
    end
  end

  // Memory is not reset; a write is dropped if reset lands on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset && word_done_c) begin
      mem_q[load_count_q[AW-1:0]] <= NBITS'(load_word_c);
    end
  end

`ifdef IF_HALT_DETECT_EN
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (i_step && !i_flush && !i_stall && (fetch_word_c == '1)) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign o_halt = halt_q;
`else
  assign o_halt = 1'b0;
`endif

  assign o_instr      = instr_q;
  assign o_pc_4       = pc_4_q;
  assign o_load_count = load_count_q;
  assign o_load_full  = load_full_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (default parameters).
module tb_if_id_stage;

  localparam int unsigned NBITS = 32;
  localparam int unsigned DEPTH = 256;

`ifdef IF_HALT_DETECT_EN
  localparam logic HALT_EXP = 1'b1;
`else
  localparam logic HALT_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset, i_step, i_stall, i_flush;
  logic [31:0] i_pc, i_pc_4;
  logic        i_load_valid, i_load_clear;
  logic [7:0]  i_load_byte;
  logic [31:0] o_instr, o_pc_4;
  logic [8:0]  o_load_count;
  logic        o_load_full, o_halt;

  int checks   = 0;
  int failures = 0;

  if_id_stage #(.NBITS(NBITS), .IMEM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_step(i_step), .i_stall(i_stall),
    .i_flush(i_flush), .i_pc(i_pc), .i_pc_4(i_pc_4),
    .i_load_valid(i_load_valid), .i_load_byte(i_load_byte), .i_load_clear(i_load_clear),
    .o_instr(o_instr), .o_pc_4(o_pc_4), .o_load_count(o_load_count),
    .o_load_full(o_load_full), .o_halt(o_halt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_step(input logic [31:0] pc, input logic [31:0] pc4,
                         input logic stall, input logic flush);
    i_pc = pc; i_pc_4 = pc4; i_stall = stall; i_flush = flush; i_step = 1'b1;
    tick();
    i_step = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
  endtask

  task automatic pulse_clear;
    i_load_clear = 1'b1;
    tick();
    i_load_clear = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; tick(); tick(); i_reset = 1'b0;
    checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", o_instr, 32'h0); end
    checks++; if (o_pc_4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", o_pc_4, 32'h0); end
    checks++; if (o_load_count !== 9'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_load_count); end
    checks++; if (o_load_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_load_full); end
    checks++; if (o_halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", o_halt); end
  endtask

  task automatic test_load;
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    checks++; if (o_load_count !== 9'd0) begin failures++; $display("FAIL load_partial_count got=%0d exp=0", o_load_count); end
    send_byte(8'h05);
    checks++; if (o_load_count !== 9'd1) begin failures++; $display("FAIL load_count got=%0d exp=1", o_load_count); end
    do_step(32'h0, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h20080005) begin failures++; $display("FAIL load_fetch got=%h exp=%h", o_instr, 32'h20080005); end
    checks++; if (o_pc_4 !== 32'h4) begin failures++; $display("FAIL load_pc4 got=%h exp=%h", o_pc_4, 32'h4); end
  endtask

  task automatic test_flush_stall;
    do_step(32'h0, 32'h44, 1'b1, 1'b1);
    checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL flush_instr got=%h exp=%h", o_instr, 32'h0); end
    checks++; if (o_pc_4 !== 32'h44) begin failures++; $display("FAIL flush_pc4 got=%h exp=%h", o_pc_4, 32'h44); end
    do_step(32'h2, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h20080005) begin failures++; $display("FAIL lowbits_ignored got=%h exp=%h", o_instr, 32'h20080005); end
    do_step(32'h400, 32'h8, 1'b1, 1'b0);
    checks++; if (o_instr !== 32'h20080005) begin failures++; $display("FAIL stall_instr got=%h exp=%h", o_instr, 32'h20080005); end
    checks++; if (o_pc_4 !== 32'h4) begin failures++; $display("FAIL stall_pc4 got=%h exp=%h", o_pc_4, 32'h4); end
  endtask

  task automatic test_step_gating;
    i_step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_pc   = 32'h400 + 32'(k * 4);
      i_pc_4 = 32'h404 + 32'(k * 4);
      tick();
      checks++; if (o_instr !== 32'h20080005) begin failures++; $display("FAIL gate_instr[%0d] got=%h exp=%h", k, o_instr, 32'h20080005); end
      checks++; if (o_pc_4 !== 32'h4) begin failures++; $display("FAIL gate_pc4[%0d] got=%h exp=%h", k, o_pc_4, 32'h4); end
    end
  endtask

  task automatic test_out_of_range;
    do_step(32'h400, 32'h404, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL oor_400 got=%h exp=%h", o_instr, 32'h0); end
    checks++; if (o_pc_4 !== 32'h404) begin failures++; $display("FAIL oor_pc4 got=%h exp=%h", o_pc_4, 32'h404); end
    do_step(32'h0, 32'h4, 1'b0, 1'b0);
    do_step(32'h80000000, 32'h80000004, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL oor_msb got=%h exp=%h", o_instr, 32'h0); end
  endtask

  task automatic test_clear;
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_load_clear = 1'b1; i_load_valid = 1'b1; i_load_byte = 8'hCC;
    tick();
    i_load_clear = 1'b0; i_load_valid = 1'b0;
    checks++; if (o_load_count !== 9'd0) begin failures++; $display("FAIL clear_count got=%0d exp=0", o_load_count); end
    send_word(32'h01020304);
    checks++; if (o_load_count !== 9'd1) begin failures++; $display("FAIL clear_reload_count got=%0d exp=1", o_load_count); end
    do_step(32'h0, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h01020304) begin failures++; $display("FAIL clear_reload_word got=%h exp=%h", o_instr, 32'h01020304); end
  endtask

  task automatic test_halt;
    pulse_clear();
    send_word(32'hFFFFFFFF);
    checks++; if (o_halt !== 1'b0) begin failures++; $display("FAIL halt_before_fetch got=%b exp=0", o_halt); end
    do_step(32'h0, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'hFFFFFFFF) begin failures++; $display("FAIL halt_instr got=%h exp=%h", o_instr, 32'hFFFFFFFF); end
    checks++; if (o_halt !== HALT_EXP) begin failures++; $display("FAIL halt_set got=%b exp=%b", o_halt, HALT_EXP); end
    do_step(32'h0, 32'h4, 1'b0, 1'b1);
    checks++; if (o_halt !== HALT_EXP) begin failures++; $display("FAIL halt_after_flush got=%b exp=%b", o_halt, HALT_EXP); end
    // Mid-load reset: two bytes in, then reset with a byte presented on the same edge.
    pulse_clear();
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_reset = 1'b1; i_load_valid = 1'b1; i_load_byte = 8'hCC; i_step = 1'b1;
    tick();
    i_reset = 1'b0; i_load_valid = 1'b0; i_step = 1'b0;
    checks++; if (o_halt !== 1'b0) begin failures++; $display("FAIL halt_reset got=%b exp=0", o_halt); end
    checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL midreset_instr got=%h exp=%h", o_instr, 32'h0); end
    checks++; if (o_load_count !== 9'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", o_load_count); end
    do_step(32'h0, 32'h4, 1'b1, 1'b0);
    send_word(32'h11223344);
    checks++; if (o_load_count !== 9'd1) begin failures++; $display("FAIL midreset_reload_count got=%0d exp=1", o_load_count); end
    do_step(32'h0, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h11223344) begin failures++; $display("FAIL midreset_word got=%h exp=%h", o_instr, 32'h11223344); end
  endtask

  task automatic test_overflow;
    pulse_clear();
    for (int w = 0; w < DEPTH; w++) begin
      send_word(32'hC0DE0000 | 32'(w));
      if (w == DEPTH - 2) begin
        checks++; if (o_load_full !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", o_load_full); end
      end
    end
    checks++; if (o_load_count !== 9'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", o_load_count, DEPTH); end
    checks++; if (o_load_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", o_load_full); end
    send_word(32'hDEADBEEF);
    checks++; if (o_load_count !== 9'(DEPTH)) begin failures++; $display("FAIL overflow_count got=%0d exp=%0d", o_load_count, DEPTH); end
    checks++; if (o_load_full !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", o_load_full); end
    do_step(32'h0, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'hC0DE0000) begin failures++; $display("FAIL overflow_mem0 got=%h exp=%h", o_instr, 32'hC0DE0000); end
    do_step(32'h3FC, 32'h400, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'hC0DE00FF) begin failures++; $display("FAIL overflow_last got=%h exp=%h", o_instr, 32'hC0DE00FF); end
  endtask

  task automatic test_back_to_back;
    // Fetch of a word on the same edge it is overwritten sees the old contents.
    pulse_clear();
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    i_pc = 32'h0; i_pc_4 = 32'h4; i_step = 1'b1;
    send_byte(8'h88);
    i_step = 1'b0;
    checks++; if (o_instr !== 32'hC0DE0000) begin failures++; $display("FAIL rw_old got=%h exp=%h", o_instr, 32'hC0DE0000); end
    do_step(32'h3, 32'h4, 1'b0, 1'b0);
    checks++; if (o_instr !== 32'h55667788) begin failures++; $display("FAIL rw_new got=%h exp=%h", o_instr, 32'h55667788); end
    checks++; if (o_load_full !== 1'b0) begin failures++; $display("FAIL rw_full got=%b exp=0", o_load_full); end
  endtask

  initial begin
    i_reset = 1'b1; i_step = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_pc = '0; i_pc_4 = '0; i_load_valid = 1'b0; i_load_byte = '0; i_load_clear = 1'b0;
    test_reset();
    test_load();
    test_flush_stall();
    test_step_gating();
    test_out_of_range();
    test_clear();
    test_halt();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
